// File: rtl/dmac_param.sv
// Parametrised DMA controller: bus slave for programming, bus master for word copies.
// Optional DMAC_STRIDE_EN adds a per-descriptor address stride register at offset 0x9.
module dmac_param #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SIZE_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [3:0]        s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              interrupt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_GNT, ST_READ, ST_WRITE, ST_POP, ST_DONE
    } state_t;

    state_t            r_state;
    logic              r_op_clear;
    logic              r_int_en;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [SIZE_W-1:0] r_size;
    logic [1:0]        r_opmode;
    logic [ADDR_W-1:0] w_push_stride;

    logic              w_wr;
    logic              w_start;
    logic              w_push;

    assign w_wr    = s_sel & s_wr;
    assign w_start = w_wr && (s_addr == 4'h0) && s_din[0];
    assign w_push  = w_wr && (s_addr == 4'h3) && s_din[0];

`ifdef DMAC_STRIDE_EN
    logic [ADDR_W-1:0] r_stride;
    assign w_push_stride = r_stride;
`else
    assign w_push_stride = ADDR_W'(1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_clear <= 1'b0;
            r_int_en   <= 1'b0;
            r_src      <= '0;
            r_dst      <= '0;
            r_size     <= '0;
            r_opmode   <= '0;
`ifdef DMAC_STRIDE_EN
            r_stride   <= ADDR_W'(1);
`endif
        end else if (w_wr) begin
            case (s_addr)
                4'h1: r_op_clear <= s_din[0];
                4'h2: r_int_en   <= s_din[0];
                4'h4: r_src      <= s_din[ADDR_W-1:0];
                4'h5: r_dst      <= s_din[ADDR_W-1:0];
                4'h6: r_size     <= s_din[SIZE_W-1:0];
                4'h8: r_opmode   <= s_din[1:0];
`ifdef DMAC_STRIDE_EN
                4'h9: r_stride   <= s_din[ADDR_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Descriptor FIFO; storage is not reset, only pointers and count
    logic [ADDR_W-1:0] r_f_src    [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_f_dst    [FIFO_DEPTH];
    logic [SIZE_W-1:0] r_f_size   [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_f_stride [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_pop;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = w_push & ~w_full;
    assign w_pop     = (r_state == ST_POP) & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_f_src[r_wptr]    <= r_src;
            r_f_dst[r_wptr]    <= r_dst;
            r_f_size[r_wptr]   <= r_size;
            r_f_stride[r_wptr] <= w_push_stride;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PW'(1);
            if (w_pop)     r_rptr <= r_rptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
            if (r_op_clear)
                r_ovf <= 1'b0;
            else if (w_push & w_full)
                r_ovf <= 1'b1;
        end
    end

    // Transfer engine
    logic              r_mreq;
    logic              r_mwr;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_cur_src;
    logic [ADDR_W-1:0] r_cur_dst;
    logic [ADDR_W-1:0] r_cur_stride;
    logic [SIZE_W-1:0] r_rem;
    logic              r_op_done;
    logic [ADDR_W-1:0] w_nxt_src;
    logic [ADDR_W-1:0] w_nxt_dst;

    assign w_nxt_src = r_cur_src + (r_opmode[0] ? r_cur_stride : '0);
    assign w_nxt_dst = r_cur_dst + (r_opmode[1] ? r_cur_stride : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_mreq       <= 1'b0;
            r_mwr        <= 1'b0;
            r_maddr      <= '0;
            r_data       <= '0;
            r_cur_src    <= '0;
            r_cur_dst    <= '0;
            r_cur_stride <= '0;
            r_rem        <= '0;
            r_op_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (w_empty) begin
                            r_state   <= ST_DONE;
                            r_op_done <= 1'b1;
                        end else begin
                            r_state <= ST_POP;
                        end
                    end
                end
                ST_POP: begin
                    if (w_empty) begin
                        r_state   <= ST_DONE;
                        r_op_done <= 1'b1;
                        r_mreq    <= 1'b0;
                    end else begin
                        r_cur_src    <= r_f_src[r_rptr];
                        r_cur_dst    <= r_f_dst[r_rptr];
                        r_cur_stride <= r_f_stride[r_rptr];
                        r_rem        <= r_f_size[r_rptr];
                        // zero-size descriptors are consumed without bus activity
                        if (r_f_size[r_rptr] != '0) begin
                            r_state <= ST_WAIT_GNT;
                            r_mreq  <= 1'b1;
                        end
                    end
                end
                ST_WAIT_GNT: begin
                    if (m_grant) begin
                        r_state <= ST_READ;
                        r_maddr <= r_cur_src;
                        r_mwr   <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (m_grant) begin
                        r_data  <= m_din;
                        r_maddr <= r_cur_dst;
                        r_mwr   <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (m_grant) begin
                        r_cur_src <= w_nxt_src;
                        r_cur_dst <= w_nxt_dst;
                        r_rem     <= r_rem - SIZE_W'(1);
                        r_mwr     <= 1'b0;
                        if (r_rem == SIZE_W'(1)) begin
                            r_state <= ST_POP;
                            r_mreq  <= 1'b0;
                        end else begin
                            r_state <= ST_READ;
                            r_maddr <= w_nxt_src;
                        end
                    end
                end
                ST_DONE: begin
                    if (r_op_clear) begin
                        r_state   <= ST_IDLE;
                        r_op_done <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A write strobe is only presented while the bus is actually granted
    assign m_req     = r_mreq;
    assign m_wr      = r_mwr & m_grant;
    assign m_addr    = r_maddr;
    assign m_dout    = r_data;
    assign interrupt = r_op_done & r_int_en;

    logic              w_busy;
    logic [DATA_W-1:0] w_status;

    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);

    always_comb begin
        w_status          = '0;
        w_status[0]       = r_ovf;
        w_status[CW:1]    = r_count;
        w_status[CW+1]    = w_busy;
        w_status[CW+2]    = r_op_done;
    end

    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (s_addr)
                4'h1: s_dout[0]          = r_op_clear;
                4'h2: s_dout[0]          = r_int_en;
                4'h4: s_dout[ADDR_W-1:0] = r_src;
                4'h5: s_dout[ADDR_W-1:0] = r_dst;
                4'h6: s_dout[SIZE_W-1:0] = r_size;
                4'h7: s_dout             = w_status;
                4'h8: s_dout[1:0]        = r_opmode;
`ifdef DMAC_STRIDE_EN
                4'h9: s_dout[ADDR_W-1:0] = r_stride;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_param.sv
// Directed bench for dmac_param: programs descriptors over the slave port and
// checks every master write (address, data, source read, latency) against hand values.
module tb_dmac_param;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel, s_wr;
    logic [3:0]  s_addr;
    logic [31:0] s_din, s_dout;
    logic        m_req, m_grant, m_wr;
    logic [7:0]  m_addr;
    logic [31:0] m_dout, m_din;
    logic        interrupt;

    int ncmp = 0;
    int nfail = 0;
    int unsigned cyc = 0;

    dmac_param #(.DATA_W(32), .ADDR_W(8), .FIFO_DEPTH(4), .SIZE_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
        .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .m_din(m_din), .interrupt(interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memval(input logic [7:0] a);
        return {24'hC0DE00, a};
    endfunction

    assign m_din = memval(m_addr);

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic [7:0]  ra;
        logic [31:0] lat;
    } wr_t;

    wr_t         wq[$];
    logic [7:0]  last_ra = '0;
    int unsigned last_rc = 0;

    always @(negedge clk) begin
        if (m_wr) wq.push_back({m_addr, m_dout, last_ra, 32'(cyc - last_rc)});
        if (m_req && m_grant && !m_wr) begin
            last_ra = m_addr;
            last_rc = cyc;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        tick();
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
    endtask

    task automatic bus_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1;
        check(tag, s_dout, exp);
        s_sel = 1'b0;
    endtask

    task automatic push(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] size);
        bus_wr(4'h4, {24'h0, src});
        bus_wr(4'h5, {24'h0, dst});
        bus_wr(4'h6, {24'h0, size});
        bus_wr(4'h3, 32'h1);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wq.size() < n; i++) tick();
    endtask

    task automatic wait_irq(input int budget);
        for (int i = 0; i < budget && !interrupt; i++) tick();
    endtask

    task automatic clear_op();
        bus_wr(4'h1, 32'h1);
        tick();
        bus_wr(4'h1, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0; m_grant = 1'b1;
        tick(); tick(); tick();
        reset_n = 1'b1;
        tick();

        // reset state
        for (int r = 0; r < 10; r++) bus_rd($sformatf("rst_reg%0d", r), 4'(r), 32'h0);
        check("rst_m_req", m_req, 0);
        check("rst_m_wr", m_wr, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_irq", interrupt, 0);

        // two src-incrementing descriptors
        push(8'h20, 8'h11, 8'd9);
        push(8'h40, 8'h10, 8'd9);
        bus_wr(4'h8, 32'h1);
        bus_wr(4'h2, 32'h1);
        bus_rd("t1_status_pre", 4'h7, 32'h04);
        wq.delete();
        bus_wr(4'h0, 32'h1);
        wait_writes(18, 200);
        wait_irq(20);
        check("t1_irq", interrupt, 1);
        check("t1_nwr", wq.size(), 18);
        for (int i = 0; i < 18 && i < wq.size(); i++) begin
            logic [7:0] sa, da;
            sa = (i < 9) ? 8'(8'h20 + i) : 8'(8'h40 + i - 9);
            da = (i < 9) ? 8'h11 : 8'h10;
            check($sformatf("t1_wr%0d", i), wq[i], {da, memval(sa), sa, 32'd1});
        end
        bus_rd("t1_status_done", 4'h7, 32'h20);
        clear_op();
        check("t1_irq_clr", interrupt, 0);
        bus_rd("t1_status_idle", 4'h7, 32'h00);

        // dst-incrementing with a grant drop mid-run
        wq.delete();
        bus_wr(4'h8, 32'h2);
        push(8'h12, 8'h60, 8'h12);
        bus_wr(4'h0, 32'h1);
        wait_writes(5, 100);
        m_grant = 1'b0;
        tick();
        check("t2_req_hold", m_req, 1);
        check("t2_wr_gated", m_wr, 0);
        tick(); tick();
        m_grant = 1'b1;
        wait_writes(18, 200);
        wait_irq(20);
        tick(); tick();
        check("t2_irq", interrupt, 1);
        check("t2_nwr", wq.size(), 18);
        for (int i = 0; i < 18 && i < wq.size(); i++)
            check($sformatf("t2_wr%0d", i), {wq[i].a, wq[i].d, wq[i].ra},
                  {8'(8'h60 + i), memval(8'h12), 8'h12});
        clear_op();

        // overflow: five pushes into a four-deep FIFO
        wq.delete();
        bus_wr(4'h8, 32'h0);
        for (int k = 0; k < 5; k++)
            push(8'(8'h80 + k), (k == 4) ? 8'h99 : 8'(8'h90 + k), 8'd1);
        bus_rd("t3_status_full", 4'h7, 32'h09);
        bus_wr(4'h0, 32'h1);
        wait_irq(100);
        check("t3_irq", interrupt, 1);
        check("t3_nwr", wq.size(), 4);
        for (int k = 0; k < 4 && k < wq.size(); k++)
            check($sformatf("t3_wr%0d", k), {wq[k].a, wq[k].d, wq[k].ra},
                  {8'(8'h90 + k), memval(8'(8'h80 + k)), 8'(8'h80 + k)});
        bus_rd("t3_status_done", 4'h7, 32'h21);
        clear_op();
        bus_rd("t3_status_clr", 4'h7, 32'h00);

        // both increment with address wrap
        wq.delete();
        bus_wr(4'h8, 32'h3);
        push(8'hFE, 8'hFF, 8'd3);
        bus_wr(4'h0, 32'h1);
        wait_irq(100);
        check("t4_nwr", wq.size(), 3);
        if (wq.size() >= 3) begin
            check("t4_wr0", wq[0], {8'hFF, memval(8'hFE), 8'hFE, 32'd1});
            check("t4_wr1", wq[1], {8'h00, memval(8'hFF), 8'hFF, 32'd1});
            check("t4_wr2", wq[2], {8'h01, memval(8'h00), 8'h00, 32'd1});
        end
        clear_op();

        // asynchronous reset in the middle of a write
        bus_wr(4'h8, 32'h1);
        push(8'h00, 8'h30, 8'd20);
        bus_wr(4'h0, 32'h1);
        for (int i = 0; i < 100 && !m_wr; i++) @(negedge clk);
        check("t5_in_write", m_wr, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_m_wr", m_wr, 0);
        check("t5_rst_m_req", m_req, 0);
        tick();
        reset_n = 1'b1;
        tick();
        bus_rd("t5_status", 4'h7, 32'h00);
        bus_rd("t5_opmode", 4'h8, 32'h00);
        check("t5_m_addr", m_addr, 0);
        check("t5_irq", interrupt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
